// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter
// Round-robin arbiter sharing the AHB-to-APB bridge slave port among NUM_M
// masters. It has a per-tenure beat limit and honours HLOCK. Address-phase
// signals follow HMASTER. Write data follows the data-phase owner, which lags
// HMASTER by one accepted address phase. Bridge responses go to all masters.
module ahb_bridge_arbiter #(
    parameter int NUM_M     = 3,
    parameter int MAX_BEATS = 8,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_M-1:0]    HBUSREQ,
    input  logic [NUM_M-1:0]    HLOCK,
    output logic [NUM_M-1:0]    HGRANT,
    output logic [1:0]          HMASTER,
    input  logic [NUM_M*AW-1:0] HADDR_M,
    input  logic [NUM_M*2-1:0]  HTRANS_M,
    input  logic [NUM_M-1:0]    HWRITE_M,
    input  logic [NUM_M*3-1:0]  HSIZE_M,
    input  logic [NUM_M*DW-1:0] HWDATA_M,
    output logic [AW-1:0]       HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [DW-1:0]       HWDATA,
    output logic                HREADYin,
    input  logic                HREADYout,
    output logic                HREADY,
    output logic [1:0]          HRESP,
    input  logic [1:0]          HRESP_B,
    output logic [DW-1:0]       HRDATA,
    input  logic [DW-1:0]       HRDATA_B
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BEATS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

    logic [NUM_M-1:0] grant;
    logic [1:0]       grant_idx;
    logic [1:0]       hmaster;
    logic [1:0]       data_owner;
    logic [1:0]       rr_ptr;
    logic [CW-1:0]    beat_cnt;

    logic [3:0]       req4;
    logic [3:0]       lock4;
    logic             any_req;
    logic             rot_found;
    logic [1:0]       rot_idx;
    logic [1:0]       cand;
    logic [1:0]       next_idx;
    logic [1:0]       next_rr;
    logic             beat;

    // Master buses padded out to four slots so a 2-bit index always fits.
    logic [AW-1:0]    addr_a  [4];
    logic [1:0]       trans_a [4];
    logic             wr_a    [4];
    logic [2:0]       size_a  [4];
    logic [DW-1:0]    wdata_a [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_m
        if (gi < NUM_M) begin : g_on
            assign addr_a[gi]  = HADDR_M[gi*AW +: AW];
            assign trans_a[gi] = HTRANS_M[gi*2 +: 2];
            assign wr_a[gi]    = HWRITE_M[gi];
            assign size_a[gi]  = HSIZE_M[gi*3 +: 3];
            assign wdata_a[gi] = HWDATA_M[gi*DW +: DW];
        end else begin : g_off
            assign addr_a[gi]  = '0;
            assign trans_a[gi] = '0;
            assign wr_a[gi]    = 1'b0;
            assign size_a[gi]  = '0;
            assign wdata_a[gi] = '0;
        end
    end

    assign req4    = 4'(HBUSREQ);
    assign lock4   = 4'(HLOCK);
    assign any_req = |HBUSREQ;

    // Round-robin scan starting after rr_ptr.
    // It skips the current owner and finds any other requester.
    always_comb begin
        rot_idx   = grant_idx;
        rot_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = 2'((int'(rr_ptr) + k) % NUM_M);
            if (!rot_found && cand != grant_idx && req4[cand]) begin
                rot_found = 1'b1;
                rot_idx   = cand;
            end
        end
    end

    // Grant decision: idle goes to the default master, then lock hold, then keep, then rotate.
    always_comb begin
        next_idx = grant_idx;
        next_rr  = rr_ptr;
        if (!any_req) begin
            next_idx = '0;
        end else if (lock4[grant_idx] && req4[grant_idx]) begin
            next_idx = grant_idx;
        end else if ((req4[grant_idx] && beat_cnt < CNT_LAST) || !rot_found) begin
            next_idx = grant_idx;
        end else begin
            next_idx = rot_idx;
            next_rr  = rot_idx;
        end
    end

    // Only beats issued by the granted master count toward its tenure.
    // The trailing address phase of a master losing the grant is not counted.
    assign beat = HTRANS[1] && (hmaster == grant_idx);

    // Ownership pipeline: grant -> address owner -> data owner, advancing on HREADY.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant      <= NUM_M'(1);
            grant_idx  <= '0;
            hmaster    <= '0;
            data_owner <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
        end else if (HREADYout) begin
            grant      <= NUM_M'(1) << next_idx;
            grant_idx  <= next_idx;
            rr_ptr     <= next_rr;
            hmaster    <= grant_idx;
            data_owner <= hmaster;
            if (next_idx != grant_idx) begin
                beat_cnt <= '0;
            end else if (beat && beat_cnt != CNT_MAX) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign HGRANT   = grant;
    assign HMASTER  = hmaster;
    assign HADDR    = addr_a[hmaster];
    assign HTRANS   = trans_a[hmaster];
    assign HWRITE   = wr_a[hmaster];
    assign HSIZE    = size_a[hmaster];
    assign HWDATA   = wdata_a[data_owner];
    assign HREADYin = HREADYout;
    assign HREADY   = HREADYout;
    assign HRESP    = HRESP_B;
    assign HRDATA   = HRDATA_B;

endmodule
